// File: rtl/mem_copier_if.sv
// Command and RAM-port bundle for the mem_copier block-copy/fill engine.
// slave is the engine side; master is the requester/RAM side.
interface mem_copier_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             mode;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      pattern;
    logic             busy;
    logic             done;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    modport slave (
        input  start, mode, src, dst, len, pattern, mem_rdata,
        output busy, done, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output start, mode, src, dst, len, pattern, mem_rdata,
        input  busy, done, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_copier.sv
// Word-granular copy/fill engine driving one port of a byte-addressed RAM.
// Copy alternates READ/WRITE per word; fill issues back-to-back WRITEs.
module mem_copier #(
    parameter int LEN_W = 16
) (
    input  logic          m_clock,
    input  logic          p_reset,
    mem_copier_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [31:0]      pat_q, pat_d;
    logic [31:0]      buf_q, buf_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            pat_q     <= '0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            pat_q     <= pat_d;
            buf_q     <= buf_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        pat_d     = pat_q;
        buf_d     = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    src_ptr_d = bus.src;
                    dst_ptr_d = bus.dst;
                    cnt_d     = bus.len;
                    mode_d    = bus.mode;
                    pat_d     = bus.pattern;
                    if (bus.len == '0) begin
                        state_d = S_DONE;
                    end else if (bus.mode) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                buf_d     = bus.mem_rdata;
                src_ptr_d = src_ptr_q + 32'd4;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                dst_ptr_d = dst_ptr_q + 32'd4;
                cnt_d     = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded only from registered state
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        unique case (state_q)
            S_READ: begin
                bus.mem_addr = src_ptr_q;
                bus.busy     = 1'b1;
            end
            S_WRITE: begin
                bus.mem_addr  = dst_ptr_q;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = mode_q ? pat_q : buf_q;
                bus.busy      = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.mem_addr = '0;
            end
        endcase
    end
endmodule
